// File: rtl/seq_det_prog.sv
// Run-time programmable serial sequence detector.
// Shifts in valid serial bits and compares the last PAT_W of them with a
// loadable pattern. Supports overlapping and non-overlapping detection and
// keeps a saturating match counter.
module seq_det_prog #(
    parameter int              PAT_W     = 4,
    parameter int              CNT_W     = 8,
    parameter logic [PAT_W-1:0] RESET_PAT = 4'b1011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             overlap_en,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             det_out,
    output logic [CNT_W-1:0] det_cnt,
    output logic             cnt_sat
);

    // fill has to be able to hold the value PAT_W itself
    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    typedef enum logic {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               det_q, det_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [PAT_W-1:0]   hist_upd;
    logic               match;
    logic               sat;

    assign sat      = &cnt_q;
    assign hist_upd = {hist_q[PAT_W-2:0], ser_in};

    // Next-state: pattern load, history shift, fill/arm FSM, match and counter
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        match   = 1'b0;

        if (pat_load) begin
            // a bit arriving in the load cycle is deliberately dropped
            pat_d   = pat_in;
            fill_d  = '0;
            state_d = S_FILL;
        end else if (ser_valid) begin
            hist_d = hist_upd;
            case (state_q)
                S_FILL: begin
                    if (fill_q == FILL_LAST) begin
                        // completing bit: evaluate against the updated history
                        match = (hist_upd == pat_q);
                        if (match && !overlap_en) begin
                            state_d = S_FILL;
                            fill_d  = '0;
                        end else begin
                            state_d = S_ARMED;
                            fill_d  = FILL_FULL;
                        end
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                S_ARMED: begin
                    match = (hist_upd == pat_q);
                    if (match && !overlap_en) begin
                        state_d = S_FILL;
                        fill_d  = '0;
                    end
                end
                default: begin
                    state_d = S_FILL;
                    fill_d  = '0;
                end
            endcase
        end

        det_d = match;

        // clear has priority over counting a simultaneous match
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (match && !sat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset overriding every other input
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FILL;
            pat_q   <= RESET_PAT;
            hist_q  <= '0;
            fill_q  <= '0;
            det_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            det_q   <= det_d;
            cnt_q   <= cnt_d;
        end
    end

    assign det_out = det_q;
    assign det_cnt = cnt_q;
    assign cnt_sat = sat;

endmodule

// File: tb/tb_seq_det_prog.sv
// Bench for seq_det_prog: two instances (8-bit and 2-bit counters) share one
// stimulus stream and are compared every cycle against a window-based model.
module tb_seq_det_prog;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ser_in = 1'b0;
    logic       ser_valid = 1'b0;
    logic       overlap_en = 1'b1;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic       cnt_clr = 1'b0;

    logic       det8, sat8, det2, sat2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_det_prog #(.PAT_W(4), .CNT_W(8), .RESET_PAT(4'b1011)) dut8 (
        .clk(clk), .reset(reset), .ser_in(ser_in), .ser_valid(ser_valid),
        .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in),
        .cnt_clr(cnt_clr), .det_out(det8), .det_cnt(cnt8), .cnt_sat(sat8)
    );

    seq_det_prog #(.PAT_W(4), .CNT_W(2), .RESET_PAT(4'b1011)) dut2 (
        .clk(clk), .reset(reset), .ser_in(ser_in), .ser_valid(ser_valid),
        .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in),
        .cnt_clr(cnt_clr), .det_out(det2), .det_cnt(cnt2), .cnt_sat(sat2)
    );

    // ---------------- behavioural model ----------------
    // Keeps the last four valid bits as a list and the number of valid bits
    // seen since the last restart; a match needs at least four such bits.
    bit   m_q[$];
    int   m_fill = 0;
    int   m_pat  = 11;
    bit   m_det  = 0;
    int   m_c8   = 0;
    int   m_c2   = 0;

    task automatic model_step();
        int win;
        bit m;
        if (reset) begin
            m_pat  = 11;
            m_q.delete();
            m_fill = 0;
            m_det  = 0;
            m_c8   = 0;
            m_c2   = 0;
        end else begin
            m = 0;
            if (pat_load) begin
                m_pat  = int'(pat_in);
                m_fill = 0;
            end else if (ser_valid) begin
                m_q.push_back(ser_in);
                if (m_q.size() > 4) void'(m_q.pop_front());
                m_fill++;
                if (m_fill >= 4) begin
                    win = 0;
                    foreach (m_q[i]) win = win * 2 + int'(m_q[i]);
                    if (win == m_pat) begin
                        m = 1;
                        if (!overlap_en) m_fill = 0;
                    end
                end
            end
            m_det = m;
            if (cnt_clr) begin
                m_c8 = 0;
                m_c2 = 0;
            end else if (m) begin
                if (m_c8 < 255) m_c8++;
                if (m_c2 < 3) m_c2++;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        chk("det8", 32'(det8), 32'(m_det));
        chk("cnt8", 32'(cnt8), 32'(m_c8));
        chk("sat8", 32'(sat8), 32'(m_c8 == 255));
        chk("det2", 32'(det2), 32'(m_det));
        chk("cnt2", 32'(cnt2), 32'(m_c2));
        chk("sat2", 32'(sat2), 32'(m_c2 == 3));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        ser_valid = 1'b1;
        ser_in    = b;
        tick();
        ser_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic send_stream(input logic [15:0] bits, input int n);
        logic [15:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) send(v[i]);
    endtask

    // literal expectation applied to both the DUT and the model
    task automatic lit(input string name, input logic [31:0] dut_v, input int mod_v, input int exp);
        chk({name, "_dut"}, dut_v, 32'(exp));
        chk({name, "_model"}, 32'(mod_v), 32'(exp));
    endtask

    initial begin
        tick();
        reset = 1'b0;
        lit("rst_det", 32'(det8), int'(m_det), 0);
        lit("rst_cnt", 32'(cnt8), m_c8, 0);
        chk("rst_sat", 32'(sat8), 32'd0);
        $display("txn: reset state");

        // overlapping stream 1011011 -> two detections
        overlap_en = 1'b1;
        send_stream(16'b1011, 4);
        lit("ovl_det4", 32'(det8), int'(m_det), 1);
        send_stream(16'b011, 3);
        lit("ovl_det7", 32'(det8), int'(m_det), 1);
        lit("ovl_cnt", 32'(cnt8), m_c8, 2);
        $display("txn: overlap stream 1011011");

        // non-overlapping: only the first detection
        do_reset();
        overlap_en = 1'b0;
        send_stream(16'b1011, 4);
        lit("novl_det4", 32'(det8), int'(m_det), 1);
        send_stream(16'b011, 3);
        lit("novl_det7", 32'(det8), int'(m_det), 0);
        lit("novl_cnt", 32'(cnt8), m_c8, 1);
        $display("txn: non-overlap stream 1011011");

        // gaps of two idle cycles between valid bits
        do_reset();
        overlap_en = 1'b1;
        send(1'b1); tick(); tick();
        send(1'b0); tick(); tick();
        send(1'b1); tick(); tick();
        send(1'b1);
        lit("gap_det", 32'(det8), int'(m_det), 1);
        tick();
        lit("gap_idle", 32'(det8), int'(m_det), 0);
        lit("gap_cnt", 32'(cnt8), m_c8, 1);
        $display("txn: gapped stream");

        // pattern load discards the same-cycle bit
        do_reset();
        pat_load = 1'b1; pat_in = 4'b1110;
        send(1'b1);
        pat_load = 1'b0;
        send_stream(16'b110, 3);
        lit("load_nodet3", 32'(det8), int'(m_det), 0);
        send(1'b0);
        send_stream(16'b1110, 4);
        lit("load_det4", 32'(det8), int'(m_det), 1);
        lit("load_cnt", 32'(cnt8), m_c8, 1);
        $display("txn: pattern load 1110");

        // saturation on the 2-bit counter, then clear with a match
        do_reset();
        overlap_en = 1'b1;
        send_stream(16'b1011011011011011, 16);
        lit("sat_cnt2", 32'(cnt2), m_c2, 3);
        chk("sat_flag2", 32'(sat2), 32'd1);
        lit("sat_cnt8", 32'(cnt8), m_c8, 5);
        send_stream(16'b01, 2);
        cnt_clr = 1'b1;
        send(1'b1);
        cnt_clr = 1'b0;
        lit("clr_cnt2", 32'(cnt2), m_c2, 0);
        lit("clr_det", 32'(det2), int'(m_det), 1);
        chk("clr_sat2", 32'(sat2), 32'd0);
        $display("txn: saturation and clear");

        // reset right after a completing bit
        do_reset();
        send_stream(16'b1011, 4);
        lit("inflight_det", 32'(det8), int'(m_det), 1);
        do_reset();
        lit("rst_kill_det", 32'(det8), int'(m_det), 0);
        lit("rst_kill_cnt", 32'(cnt8), m_c8, 0);
        send_stream(16'b011, 3);
        lit("refill_det", 32'(det8), int'(m_det), 0);
        lit("refill_cnt", 32'(cnt8), m_c8, 0);
        $display("txn: reset with match in flight");

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            reset      = ($urandom_range(0, 299) == 0);
            ser_valid  = ($urandom_range(0, 3) != 0);
            ser_in     = 1'($urandom_range(0, 1));
            overlap_en = ($urandom_range(0, 3) != 0);
            pat_load   = ($urandom_range(0, 79) == 0);
            pat_in     = 4'($urandom_range(0, 15));
            cnt_clr    = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0; ser_valid = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
        tick();
        $display("txn: random traffic 4000 cycles");

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_det_prog.md
Name: seq_det_prog

Overview:
- Parametrised, run-time programmable serial sequence detector; successor to the fixed-pattern seqDet.
- Samples a serial bit stream qualified by a valid strobe and compares the last PAT_W bits against a loadable pattern.
- Supports overlapping and non-overlapping detection and keeps a saturating match counter.
- Sits on serial receive paths as a framing/marker detector.

Parameters:
- PAT_W, 4, pattern length in bits (≥2).
- CNT_W, 8, match counter width.
- RESET_PAT, 4'b1011 (PAT_W bits), pattern value after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- ser_in  input  1  serial data bit.
- ser_valid  input  1  ser_in is sampled only when high.
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
- pat_load  input  1  load pat_in as the new pattern.
- pat_in  input  PAT_W  new pattern; bit PAT_W-1 is matched against the oldest received bit.
- cnt_clr  input  1  clear the match counter.
- det_out  output  1  one-cycle match pulse.
- det_cnt  output  CNT_W  number of matches, saturating.
- cnt_sat  output  1  high while det_cnt is all-ones.

Behaviour:
- Reset (reset=1 at posedge):
  - pattern ← RESET_PAT; history ← 0; fill ← 0.
  - FSM → FILL.
  - det_out, det_cnt and cnt_sat all ← 0.
  - Reset overrides every other input.
- History register:
  - On a valid bit: hist ← {hist[PAT_W-2:0], ser_in}, so the newest bit sits in the LSB.
  - When ser_valid=0: hist and fill hold, det_out=0.
- FSM:
  - FILL: each valid bit increments fill. The transition to ARMED happens on the valid bit that makes fill reach PAT_W. A match is evaluated on that same bit, using the updated history.
  - ARMED: every valid bit is evaluated as a match candidate.
  - A match occurs on a valid bit in ARMED, or on the completing bit in FILL, when the updated hist equals the pattern.
- Match response:
  - det_out=1 for exactly one cycle: the cycle after the posedge that sampled the completing bit, i.e. it is registered with latency 1.
  - det_cnt increments at the same posedge that sets det_out.
- Overlap mode:
  - overlap_en=1: stay in ARMED; history is reused.
  - overlap_en=0: go to FILL with fill←0. The next match needs PAT_W fresh valid bits.
  - overlap_en is sampled on the matching bit.
- pat_load:
  - At the posedge: pattern ← pat_in, fill ← 0, FSM → FILL.
  - A ser_valid bit in the same cycle is discarded.
  - det_cnt is not affected.
- Counter:
  - det_cnt saturates at 2^CNT_W-1 and never wraps.
  - cnt_sat is a combinational decode of det_cnt.
  - cnt_clr=1 together with a match: det_cnt ← 0. Clear wins and the match is not counted, but det_out still pulses.
- Reset with a match in flight: det_out is forced to 0 in the following cycle, so no pulse is produced.
- Width rules: all comparisons are PAT_W bits wide with no masking; det_cnt is unsigned.

Test Plan:
- PAT_W=4, reset pattern 1011, overlap_en=1, valid bits 1,0,1,1,0,1,1 on consecutive cycles → det_out pulses after bit 4 and after bit 7, det_cnt=2.
- Same stream with overlap_en=0 → det_out pulses only after bit 4, det_cnt=1. Bits 5–7 ("011") leave the FSM in FILL with fill=3.
- Stream 1,0,1,1 with ser_valid=0 gaps of 2 cycles between bits → exactly one det_out pulse, one cycle after the 4th valid bit, det_cnt=1. det_out stays 0 during the gaps.
- pat_load with pat_in=1110 asserted together with a valid bit, then bits 1,1,1,0 → the load-cycle bit is ignored and det_out pulses after the 4th following bit.
- CNT_W=2, overlap_en=1, stream 1,0,1,1,0,1,1,0,1,1,0,1,1,0,1,1 (5 matches) → det_cnt stops at 3 and cnt_sat=1. Then cnt_clr together with a further match gives det_cnt=0, det_out=1, cnt_sat=0.
- reset asserted on the cycle after a completing bit 1,0,1,1 → det_out=0 and det_cnt=0 in the next cycle. Then bits 0,1,1 produce no detection, because fill restarted at 0.
